// File: rtl/fp16_pkg.sv
// Shared fp16 type and constants used by the multiplier scheduler and the multiplier.
package fp16_pkg;

  typedef logic [15:0] fp16_t;

  localparam fp16_t FP16_ZERO = 16'h0000;
  localparam fp16_t FP16_ONE  = 16'h3C00;
  localparam fp16_t FP16_QNAN = 16'h7E00;

endpackage

// File: rtl/fp16mult.sv
// fp16 multiplier: round-to-nearest-even, subnormals flushed to zero, LAT register stages.
module fp16mult
  import fp16_pkg::*;
#(
  parameter int unsigned LAT = 1
) (
  input  logic  clk,
  input  logic  rst,
  input  fp16_t a,
  input  fp16_t b,
  output fp16_t x
);

  function automatic fp16_t fp16_mul(input fp16_t op_a, input fp16_t op_b);
    logic        sign;
    logic [4:0]  ea, eb;
    logic [9:0]  fa, fb;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [21:0] prod;
    logic [10:0] sig;
    logic        rnd, stk;
    logic [11:0] sig_r;
    int          e_res;
    fp16_t       res;
    sign   = op_a[15] ^ op_b[15];
    ea     = op_a[14:10];
    eb     = op_b[14:10];
    fa     = op_a[9:0];
    fb     = op_b[9:0];
    a_nan  = (ea == 5'h1F) && (fa != 10'h000);
    b_nan  = (eb == 5'h1F) && (fb != 10'h000);
    a_inf  = (ea == 5'h1F) && (fa == 10'h000);
    b_inf  = (eb == 5'h1F) && (fb == 10'h000);
    a_zero = (ea == 5'h00);
    b_zero = (eb == 5'h00);
    prod   = 22'({1'b1, fa}) * 22'({1'b1, fb});
    e_res  = int'(ea) + int'(eb) - 15;
    if (prod[21]) begin
      sig   = prod[21:11];
      rnd   = prod[10];
      stk   = |prod[9:0];
      e_res = e_res + 1;
    end else begin
      sig = prod[20:10];
      rnd = prod[9];
      stk = |prod[8:0];
    end
    sig_r = {1'b0, sig} + 12'(rnd && (stk || sig[0]));
    if (sig_r[11]) begin
      sig_r = sig_r >> 1;
      e_res = e_res + 1;
    end
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      res = FP16_QNAN;
    end else if (a_inf || b_inf || e_res >= 31) begin
      res = {sign, 5'h1F, 10'h000};
    end else if (a_zero || b_zero || e_res <= 0) begin
      res = {sign, 15'h0000};
    end else begin
      res = {sign, e_res[4:0], sig_r[9:0]};
    end
    return res;
  endfunction

  fp16_t x_comb;
  assign x_comb = fp16_mul(a, b);

  if (LAT == 0) begin : g_comb
    assign x = x_comb;
  end else begin : g_pipe
    fp16_t stage_q [LAT];
    always_ff @(posedge clk) begin
      if (!rst) begin
        for (int i = 0; i < int'(LAT); i++) stage_q[i] <= FP16_ZERO;
      end else begin
        stage_q[0] <= x_comb;
        for (int i = 1; i < int'(LAT); i++) stage_q[i] <= stage_q[i-1];
      end
    end
    assign x = stage_q[LAT-1];
  end

endmodule

// File: rtl/rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping modulo N.
module rr_pick #(
  parameter  int unsigned N   = 4,
  localparam int unsigned IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_idx,
  output logic           any
);

  logic [IDW:0]   sum;
  logic [IDW-1:0] idx;

  // ptr < N and k < N, so one conditional subtract implements the wrap.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int k = 0; k < int'(N); k++) begin
      sum = (IDW+1)'(ptr) + (IDW+1)'(k);
      idx = (sum >= (IDW+1)'(N)) ? IDW'(sum - (IDW+1)'(N)) : IDW'(sum);
      if (!any && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp16mult_rr_sched.sv
// Time-shares one fp16mult between NREQ requesters; products return to their requester.
module fp16mult_rr_sched
  import fp16_pkg::*;
#(
  parameter  int unsigned NREQ     = 4,
  parameter  int unsigned MULT_LAT = 1,
  localparam int unsigned IDW      = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [16*NREQ-1:0] req_a,
  input  logic [16*NREQ-1:0] req_b,
  output logic [NREQ-1:0]    rsp_valid,
  output fp16_t              rsp_data,
  output logic [IDW+1:0]     inflight,
  output logic               busy
);

  logic [NREQ-1:0] pick_req;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_idx;
  logic            any_gnt;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  fp16_t           opnd_a_q, opnd_b_q;
  logic            opnd_vld_q;
  logic [IDW-1:0]  opnd_id_q;
  logic            tag_vld;
  logic [IDW-1:0]  tag_id;
  logic [IDW+1:0]  inflight_q, inflight_d;
  fp16_t           a_arr [NREQ];
  fp16_t           b_arr [NREQ];

  for (genvar i = 0; i < int'(NREQ); i++) begin : g_unpack
    assign a_arr[i] = req_a[16*i +: 16];
    assign b_arr[i] = req_b[16*i +: 16];
  end

  // Masking the requests keeps ready low during reset and while disabled.
  assign pick_req = (en && rst) ? req_valid : '0;

  rr_pick #(
    .N(NREQ)
  ) u_rr_pick (
    .req    (pick_req),
    .ptr    (rr_ptr_q),
    .gnt    (gnt),
    .gnt_idx(gnt_idx),
    .any    (any_gnt)
  );

  assign req_ready = gnt;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (any_gnt) begin
      rr_ptr_d = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr_q   <= '0;
      opnd_vld_q <= 1'b0;
      opnd_id_q  <= '0;
      opnd_a_q   <= FP16_ZERO;
      opnd_b_q   <= FP16_ZERO;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      opnd_vld_q <= any_gnt;
      if (any_gnt) begin
        opnd_id_q <= gnt_idx;
        opnd_a_q  <= a_arr[gnt_idx];
        opnd_b_q  <= b_arr[gnt_idx];
      end
    end
  end

  fp16mult #(
    .LAT(MULT_LAT)
  ) u_fp16mult (
    .clk(clk),
    .rst(rst),
    .a  (opnd_a_q),
    .b  (opnd_b_q),
    .x  (rsp_data)
  );

  // Requester tag travels alongside the multiplier pipeline.
  if (MULT_LAT == 0) begin : g_tag_bypass
    assign tag_vld = opnd_vld_q;
    assign tag_id  = opnd_id_q;
  end else begin : g_tag_pipe
    logic           vld_q [MULT_LAT];
    logic [IDW-1:0] id_q  [MULT_LAT];
    always_ff @(posedge clk) begin
      if (!rst) begin
        for (int s = 0; s < int'(MULT_LAT); s++) begin
          vld_q[s] <= 1'b0;
          id_q[s]  <= '0;
        end
      end else begin
        vld_q[0] <= opnd_vld_q;
        id_q[0]  <= opnd_id_q;
        for (int s = 1; s < int'(MULT_LAT); s++) begin
          vld_q[s] <= vld_q[s-1];
          id_q[s]  <= id_q[s-1];
        end
      end
    end
    assign tag_vld = vld_q[MULT_LAT-1];
    assign tag_id  = id_q[MULT_LAT-1];
  end

  always_comb begin
    rsp_valid = '0;
    if (tag_vld) rsp_valid[tag_id] = 1'b1;
  end

  always_comb begin
    inflight_d = inflight_q;
    if (any_gnt && !tag_vld) begin
      inflight_d = inflight_q + (IDW+2)'(1);
    end else if (!any_gnt && tag_vld) begin
      inflight_d = inflight_q - (IDW+2)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) inflight_q <= '0;
    else      inflight_q <= inflight_d;
  end

  assign inflight = inflight_q;
  assign busy     = (inflight_q != '0);

endmodule

// File: tb/tb_fp16mult_rr_sched.sv
// Randomized self-checking bench with a queue-based response model.
module tb_fp16mult_rr_sched;
  import fp16_pkg::*;

  localparam int NREQ = 4;
  localparam int LAT  = 1;

  logic        clk = 1'b0;
  logic        rst, en;
  logic [3:0]  req_valid, req_ready, rsp_valid;
  logic [63:0] req_a, req_b;
  logic [15:0] rsp_data;
  logic [3:0]  inflight;
  logic        busy;

  logic        l3_en;
  logic [3:0]  l3_valid, l3_ready, l3_rsp_valid;
  logic [63:0] l3_a, l3_b;
  logic [15:0] l3_data;
  logic [3:0]  l3_inflight;
  logic        l3_busy;

  always #5 clk = ~clk;

  fp16mult_rr_sched #(.NREQ(4), .MULT_LAT(1)) dut (
    .clk(clk), .rst(rst), .en(en), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .inflight(inflight), .busy(busy)
  );

  fp16mult_rr_sched #(.NREQ(4), .MULT_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .en(l3_en), .req_valid(l3_valid), .req_ready(l3_ready),
    .req_a(l3_a), .req_b(l3_b), .rsp_valid(l3_rsp_valid), .rsp_data(l3_data),
    .inflight(l3_inflight), .busy(l3_busy)
  );

  typedef struct {
    int          due;
    int          id;
    logic [15:0] data;
  } rsp_t;

  rsp_t        exp_q[$];
  logic [15:0] prod_m [NREQ];
  int          ptr_m, cyc, exp_gnt, peak;
  int          checks, errors;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Value m*2^e encoded as fp16; callers keep m < 2048 and the result normal.
  function automatic logic [15:0] enc(input logic s, input int unsigned m, input int e);
    int p;
    p = 0;
    for (int k = 0; k < 11; k++) if (m[k]) p = k;
    return {s, 5'(p + e + 15), 10'((m << (10 - p)) & 32'h3FF)};
  endfunction

  function automatic int model_grant();
    if (!rst || !en) return -1;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (ptr_m + k) % NREQ;
      if (req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] p);
    req_valid[i]       = v;
    req_a[16*i +: 16]  = a;
    req_b[16*i +: 16]  = b;
    prod_m[i]          = p;
  endtask

  // Operands with at most 5 significant bits, so the product is exact.
  task automatic rand_req(input int i, input logic v);
    int unsigned ma, mb;
    int          ea, eb;
    logic        sa, sb;
    ma = $urandom_range(1, 31);
    mb = $urandom_range(1, 31);
    ea = int'($urandom_range(0, 8)) - 6;
    eb = int'($urandom_range(0, 8)) - 6;
    sa = 1'($urandom_range(0, 1));
    sb = 1'($urandom_range(0, 1));
    set_req(i, v, enc(sa, ma, ea), enc(sb, mb, eb), enc(sa ^ sb, ma * mb, ea + eb));
  endtask

  task automatic check_cycle();
    logic [3:0]  exp_rv;
    logic [15:0] exp_rd;
    exp_rv  = 4'b0000;
    exp_rd  = 16'h0000;
    exp_gnt = model_grant();
    check_eq("req_ready", 32'(req_ready), (exp_gnt < 0) ? 32'd0 : (32'd1 << exp_gnt));
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      exp_rv = 4'(32'd1 << exp_q[0].id);
      exp_rd = exp_q[0].data;
    end
    check_eq("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    if (exp_rv != 4'b0000) check_eq("rsp_data", 32'(rsp_data), 32'(exp_rd));
    check_eq("inflight", 32'(inflight), 32'(exp_q.size()));
    check_eq("busy", 32'(busy), 32'(exp_q.size() != 0));
    if (int'(inflight) > peak) peak = int'(inflight);
  endtask

  task automatic update_model();
    if (!rst) begin
      exp_q.delete();
      ptr_m = 0;
    end else begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) void'(exp_q.pop_front());
      if (exp_gnt >= 0) begin
        exp_q.push_back('{cyc + 1 + LAT, exp_gnt, prod_m[exp_gnt]});
        ptr_m = (exp_gnt + 1) % NREQ;
      end
    end
    cyc++;
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    update_model();
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    logic [3:0]  l3_exp_rdy, l3_exp_rv;
    logic [15:0] l3_exp_rd;
    int          l3_exp_inf [8];
    checks = 0; errors = 0; cyc = 0; ptr_m = 0; peak = 0; exp_gnt = -1;
    rst = 1'b0; en = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
    for (int i = 0; i < NREQ; i++) prod_m[i] = 16'h0000;
    l3_en = 1'b1; l3_valid = '0; l3_a = '0; l3_b = '0;
    repeat (3) step();
    rst = 1'b1;
    step();

    // Single pulses from req0 and req1, including a subnormal operand.
    set_req(0, 1'b1, 16'h4766, 16'h4826, 16'h53AC);
    step();
    req_valid = '0;
    repeat (4) step();
    set_req(1, 1'b1, 16'h00B2, 16'h4826, 16'h0000);
    step();
    req_valid = '0;
    repeat (4) step();

    // All four valid for 8 cycles, starting from a fresh pointer.
    rst = 1'b0;
    step();
    rst = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, FP16_ONE, 16'h4000, 16'h4000);
    peak = 0;
    repeat (8) step();
    req_valid = '0;
    repeat (4) step();
    check_eq("inflight_peak", 32'(peak), 32'd2);

    // Disabled with req2 waiting, then enabled.
    en = 1'b0;
    rand_req(2, 1'b1);
    repeat (5) step();
    en = 1'b1;
    step();
    req_valid = '0;
    repeat (4) step();

    // Grant to req2, reset on the next edge, then req1/req3 compete.
    rand_req(2, 1'b1);
    step();
    req_valid = '0;
    rst = 1'b0;
    step();
    rst = 1'b1;
    rand_req(1, 1'b1);
    rand_req(3, 1'b1);
    step();
    req_valid = '0;
    repeat (4) step();

    // Randomized traffic with occasional disable and reset.
    repeat (400) begin
      en  = ($urandom_range(0, 7) != 0);
      rst = ($urandom_range(0, 40) != 0);
      for (int i = 0; i < NREQ; i++) rand_req(i, 1'($urandom_range(0, 1)));
      step();
    end
    rst = 1'b1; en = 1'b1; req_valid = '0;
    repeat (6) step();

    // MULT_LAT=3 instance: back-to-back req0 then req3.
    l3_a = '0; l3_b = '0;
    l3_a[15:0]  = 16'h4766; l3_b[15:0]  = 16'h4826;
    l3_a[63:48] = FP16_ONE; l3_b[63:48] = 16'h4000;
    l3_exp_inf = '{0, 1, 2, 2, 2, 1, 0, 0};
    for (int c = 0; c < 8; c++) begin
      l3_valid   = (c == 0) ? 4'b1001 : (c == 1) ? 4'b1000 : 4'b0000;
      l3_exp_rdy = (c == 0) ? 4'b0001 : (c == 1) ? 4'b1000 : 4'b0000;
      l3_exp_rv  = (c == 4) ? 4'b0001 : (c == 5) ? 4'b1000 : 4'b0000;
      l3_exp_rd  = (c == 4) ? 16'h53AC : 16'h4000;
      @(negedge clk);
      check_eq("lat3_ready", 32'(l3_ready), 32'(l3_exp_rdy));
      check_eq("lat3_rsp_valid", 32'(l3_rsp_valid), 32'(l3_exp_rv));
      if (l3_exp_rv != 4'b0000) check_eq("lat3_rsp_data", 32'(l3_data), 32'(l3_exp_rd));
      check_eq("lat3_inflight", 32'(l3_inflight), 32'(l3_exp_inf[c]));
      @(posedge clk);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
